// File: rtl/mux_key_reg_if.sv
// mux_key_reg_if: bundles the selector inputs, load enable and results of
// mux_key_reg.
//   key         - selection key
//   lut         - packed {key,data} entries, entry 0 in the lowest bits
//   default_out - value selected when no entry key matches
//   wen         - register load enable
//   mux_out     - combinational selected value
//   hit         - combinational, some entry key equals key
//   q           - registered value
// master drives the inputs and reads the results; slave is the block itself.
interface mux_key_reg_if #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 32
) ();
    logic [KEY_LEN-1:0]                   key;
    logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut;
    logic [DATA_LEN-1:0]                  default_out;
    logic                                 wen;
    logic [DATA_LEN-1:0]                  mux_out;
    logic                                 hit;
    logic [DATA_LEN-1:0]                  q;

    modport master (
        output key, lut, default_out, wen,
        input  mux_out, hit, q
    );

    modport slave (
        input  key, lut, default_out, wen,
        output mux_out, hit, q
    );
endinterface

// File: rtl/mux_key_reg.sv
// mux_key_reg: keyed multiplexer feeding a loadable holding register.
// Typical use is the PC path: select pc+4 or a jump target and hold it.
//   clk   - rising-edge clock for q
//   rst_n - asynchronous active-low reset, q = RESET_VAL while low
//   bus   - slave side of mux_key_reg_if (key, lut, default_out, wen in;
//           mux_out, hit, q out)
// mux_out/hit are purely combinational from key, lut and default_out; q
// loads mux_out on a rising edge when wen is high.
module mux_key_reg #(
    parameter int                  NR_KEY    = 2,
    parameter int                  KEY_LEN   = 1,
    parameter int                  DATA_LEN  = 32,
    parameter logic [DATA_LEN-1:0] RESET_VAL = 32'h8000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_key_reg_if.slave  bus
);
    localparam int P = KEY_LEN + DATA_LEN;

    logic [DATA_LEN-1:0] sel;
    logic                found;
    logic [DATA_LEN-1:0] q_r;

    // Lowest-index match wins. An unknown key makes the equality unknown,
    // which the if treats as false, so X keys fall through to the default.
    always_comb begin
        sel   = bus.default_out;
        found = 1'b0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (!found && (bus.lut[i*P+DATA_LEN +: KEY_LEN] == bus.key)) begin
                sel   = bus.lut[i*P +: DATA_LEN];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= RESET_VAL;
        end else if (bus.wen) begin
            q_r <= sel;
        end
    end

    assign bus.mux_out = sel;
    assign bus.hit     = found;
    assign bus.q       = q_r;
endmodule

// File: tb/tb_mux_key_reg.sv
// tb_mux_key_reg: directed vectors against two configurations of
// mux_key_reg: a 2-entry/1-bit-key PC path and a 3-entry/2-bit-key
// priority table.
module tb_mux_key_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    mux_key_reg_if #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32)) bus_a ();
    mux_key_reg_if #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(32)) bus_b ();

    mux_key_reg #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32), .RESET_VAL(32'h8000_0000))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mux_key_reg #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(32), .RESET_VAL(32'h8000_0000))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [65:0] pack_a(input logic k1, input logic [31:0] d1,
                                           input logic k0, input logic [31:0] d0);
        return {k1, d1, k0, d0};
    endfunction

    logic [31:0] exp_q;
    logic [31:0] dnpc;
    logic [31:0] d0;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held across edges with wen=1: reset must win.
        rst_n             = 1'b0;
        bus_a.wen         = 1'b1;
        bus_a.key         = 1'b0;
        bus_a.default_out = 32'hDEAD_BEEF;
        bus_a.lut         = pack_a(1'b1, 32'h1111_1111, 1'b0, 32'h2222_2222);
        bus_b.wen         = 1'b0;
        bus_b.key         = 2'd0;
        bus_b.default_out = 32'h0000_000D;
        bus_b.lut         = {2'd1, 32'h0000_000C, 2'd2, 32'h0000_000B, 2'd2, 32'h0000_000A};
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", bus_a.q, 32'h8000_0000);
        check("reset_b", bus_b.q, 32'h8000_0000);

        // Release with wen=0: q stays at the reset value.
        @(negedge clk);
        bus_a.wen = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        check("release_hold", bus_a.q, 32'h8000_0000);

        // Sequential step: three edges of pc+4.
        exp_q = 32'h8000_0000;
        dnpc  = 32'h8000_1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_a.wen = 1'b1;
            bus_a.key = 1'b0;
            bus_a.lut = pack_a(1'b1, dnpc, 1'b0, exp_q + 32'd4);
            #1;
            check("seq_mux", bus_a.mux_out, exp_q + 32'd4);
            @(posedge clk); #1;
            exp_q = exp_q + 32'd4;
            check("seq_q", bus_a.q, exp_q);
        end
        check("seq_final", bus_a.q, 32'h8000_000C);

        // Jump then resume sequential.
        @(negedge clk);
        bus_a.key = 1'b1;
        bus_a.lut = pack_a(1'b1, 32'h8000_1000, 1'b0, 32'h8000_0010);
        #1;
        check("jump_hit", {31'd0, bus_a.hit}, 32'd1);
        @(posedge clk); #1;
        check("jump_q", bus_a.q, 32'h8000_1000);
        @(negedge clk);
        bus_a.key = 1'b0;
        bus_a.lut = pack_a(1'b1, 32'h8000_2000, 1'b0, 32'h8000_1004);
        @(posedge clk); #1;
        check("after_jump_q", bus_a.q, 32'h8000_1004);
        exp_q = 32'h8000_1004;

        // Hold: wen=0, inputs toggling, mux_out tracks, q frozen.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus_a.wen = 1'b0;
            bus_a.key = 1'(i % 2);
            dnpc      = 32'h1234_0000 + 32'(i);
            d0        = 32'h5678_0000 + 32'(i * 16);
            bus_a.lut = pack_a(1'b1, dnpc, 1'b0, d0);
            #1;
            check("hold_mux", bus_a.mux_out, (i % 2 == 1) ? dnpc : d0);
            @(posedge clk); #1;
            check("hold_q", bus_a.q, exp_q);
        end

        // No match in config A: default and hit=0.
        @(negedge clk);
        bus_a.key = 1'b0;
        bus_a.lut = pack_a(1'b1, 32'h0000_0001, 1'b1, 32'h0000_0002);
        #1;
        check("a_default_mux", bus_a.mux_out, 32'hDEAD_BEEF);
        check("a_default_hit", {31'd0, bus_a.hit}, 32'd0);

        // Priority / default table in config B.
        bus_b.key = 2'd2; #1;
        check("b_k2_mux", bus_b.mux_out, 32'h0000_000A);
        check("b_k2_hit", {31'd0, bus_b.hit}, 32'd1);
        bus_b.key = 2'd1; #1;
        check("b_k1_mux", bus_b.mux_out, 32'h0000_000C);
        check("b_k1_hit", {31'd0, bus_b.hit}, 32'd1);
        bus_b.key = 2'd3; #1;
        check("b_k3_mux", bus_b.mux_out, 32'h0000_000D);
        check("b_k3_hit", {31'd0, bus_b.hit}, 32'd0);
        bus_b.key = 2'd0; #1;
        check("b_k0_mux", bus_b.mux_out, 32'h0000_000D);
        @(negedge clk);
        bus_b.key = 2'd1;
        bus_b.wen = 1'b1;
        @(posedge clk); #1;
        check("b_load_q", bus_b.q, 32'h0000_000C);
        @(negedge clk);
        bus_b.wen = 1'b0;

        // Async reset between edges, then restart from the reset value.
        @(posedge clk); #3;
        check("pre_async_q", bus_a.q, 32'h8000_1004);
        rst_n = 1'b0;
        #1;
        check("async_q", bus_a.q, 32'h8000_0000);
        @(negedge clk);
        rst_n     = 1'b1;
        bus_a.key = 1'b0;
        bus_a.wen = 1'b1;
        bus_a.lut = pack_a(1'b1, 32'h8000_1000, 1'b0, 32'h8000_0004);
        @(posedge clk); #1;
        check("post_async_q", bus_a.q, 32'h8000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
